iter_shifter: RTL and testbench

Parametrised multi-cycle shift unit for the CPU datapath, successor to the fixed two-bit left-shift helpers used for branch and jump target formation. It supports four modes: logical left, logical right, arithmetic right and rotate right. Shift distance is runtime-variable, and the unit advances at most STEP bit positions per clock. It trades latency for a small shifter, sits beside the ALU, and uses a valid/ready handshake on both sides.

---
 rtl/shifter_pkg.sv | 22 ++
 rtl/shift_step.sv | 26 ++
 rtl/iter_shifter.sv | 114 +++++++++++
 tb/tb_iter_shifter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shift unit and the ALU decoder.
package shifter_pkg;

    localparam logic [1:0] OpcSll = 2'b00;
    localparam logic [1:0] OpcSrl = 2'b01;
    localparam logic [1:0] OpcSra = 2'b10;
    localparam logic [1:0] OpcRor = 2'b11;

    typedef enum logic [1:0] {
        OpSll = OpcSll,
        OpSrl = OpcSrl,
        OpSra = OpcSra,
        OpRor = OpcRor
    } shift_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational WIDTH-bit shifter by 0..STEP positions for one of four shift ops.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    localparam int unsigned KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        unique case (op)
            OpSll: result = data << k;
            OpSrl: result = data >> k;
            OpSra: result = $unsigned($signed(data) >>> k);
            // Shifting a doubled copy right leaves the rotated word in the low half.
            OpRor: result = WIDTH'({data, data} >> k);
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift unit: advances at most STEP bit positions per clock, valid/ready on both sides.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned STEP     = 4,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam int unsigned KW = $clog2(STEP + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    shift_op_e          op_q, op_d;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_result;

    // k = min(rem, STEP); rem only ever shrinks by k, so it cannot underflow.
    always_comb begin
        if (32'(rem_q) < STEP) begin
            k = KW'(rem_q);
        end else begin
            k = KW'(STEP);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shift_step (
        .data   (data_q),
        .k      (k),
        .op     (op_q),
        .result (step_result)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_shamt;
                    op_d    = shift_op_e'(in_op);
                    state_d = (in_shamt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                data_d = step_result;
                rem_d  = rem_q - SHAMT_W'(k);
                if (rem_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over everything; the working register keeps its last value.
        if (flush) begin
            state_d = StIdle;
            data_d  = data_q;
            rem_d   = rem_q;
            op_d    = op_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= OpSll;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = data_q;

    a_shift_rem_nonzero: assert property (
        @(posedge clk) disable iff (rst) (state_q == StShift) |-> (rem_q != '0));

    a_done_stable: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == StDone && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter with WIDTH = 32, STEP = 4.
module tb_iter_shifter;
    import shifter_pkg::*;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned STEP    = 4;
    localparam int unsigned SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [WIDTH-1:0]   in_data, out_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               lat_q[$];

    always #5 clk = ~clk;

    iter_shifter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] d, input int s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (op)
                2'b00:   r[i] = (i >= s) ? d[(i + WIDTH - s) % WIDTH] : 1'b0;
                2'b01:   r[i] = (i + s < WIDTH) ? d[(i + s) % WIDTH] : 1'b0;
                2'b10:   r[i] = (i + s < WIDTH) ? d[(i + s) % WIDTH] : d[WIDTH-1];
                default: r[i] = d[(i + s) % WIDTH];
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d, input int s);
        logic [SHAMT_W-1:0] sh;
        sh = SHAMT_W'(s);
        exp_q.push_back(ref_shift(op, d, s));
        lat_q.push_back(1 + (s + STEP - 1) / STEP);
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; lat counts cycles from the accept cycle.
    task automatic wait_valid(output int lat, output logic busy_all);
        lat      = 1;
        busy_all = busy;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            busy_all = busy_all & busy;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_data=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sll31();
        int lat, elat;
        logic ba;
        logic [WIDTH-1:0] e;
        send(2'b00, 32'h0000_0001, 31);
        in_valid = 1'b1;  // pulsed while busy: must be ignored
        in_data  = 32'h1234_5678;
        in_shamt = 5'd3;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_ready: got %b want 0", in_ready);
        end
        wait_valid(lat, ba);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        elat = lat_q.pop_front();
        checks++;
        if (out_data !== 32'h8000_0000 || out_data !== e) begin
            errors++;
            $display("FAIL sll31_data: got %h want 80000000", out_data);
        end
        checks++;
        if (lat !== elat || lat !== 9) begin
            errors++;
            $display("FAIL sll31_latency: got %0d want 9", lat);
        end
        checks++;
        if (ba !== 1'b1) begin
            errors++;
            $display("FAIL sll31_busy: got %b want 1", ba);
        end
        take();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sll31_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        int lat, elat;
        logic ba;
        logic [WIDTH-1:0] e;
        logic [1:0] ops[6] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
        logic [WIDTH-1:0] ds[6] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0003,
                                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        int ss[6] = '{5, 5, 1, 0, 0, 0};
        logic [WIDTH-1:0] want[6] = '{32'hFC00_0000, 32'h0400_0000, 32'h8000_0001,
                                      32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        int wlat[6] = '{3, 3, 2, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            send(ops[i], ds[i], ss[i]);
            wait_valid(lat, ba);
            e = exp_q.pop_front();
            elat = lat_q.pop_front();
            checks++;
            if (out_data !== want[i] || out_data !== e) begin
                errors++;
                $display("FAIL directed%0d_data: got %h want %h", i, out_data, want[i]);
            end
            checks++;
            if (lat !== wlat[i] || lat !== elat) begin
                errors++;
                $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, wlat[i]);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int lat, elat;
        logic ba;
        logic [WIDTH-1:0] e, held;
        send(2'b01, 32'hF0F0_F0F0, 8);
        wait_valid(lat, ba);
        held = out_data;
        in_valid = 1'b1;
        in_data  = 32'h0BAD_0BAD;
        in_shamt = 5'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: out_valid=%b out_data=%h in_ready=%b want 1 %h 0",
                         c, out_valid, out_data, in_ready, held);
            end
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        elat = lat_q.pop_front();
        checks++;
        if (held !== e || lat !== elat) begin
            errors++;
            $display("FAIL backpressure_result: got %h lat %0d want %h lat %0d", held, lat, e, elat);
        end
        take();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int lat, elat, seen;
        logic ba;
        logic [WIDTH-1:0] e;
        send(2'b00, 32'h0000_0001, 31);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b in_ready=%b out_valid=%b want 0 1 0",
                     busy, in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_valid: out_valid seen %0d cycles want 0", seen);
        end
        // flush coincident with in_valid in IDLE: operand dropped
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h5555_5555;
        in_shamt = 5'd4;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_reject: busy=%b in_ready=%b want 0 1", busy, in_ready);
        end
        send(2'b10, 32'h8765_4321, 13);
        wait_valid(lat, ba);
        e = exp_q.pop_front();
        elat = lat_q.pop_front();
        checks++;
        if (out_data !== e || lat !== elat) begin
            errors++;
            $display("FAIL flush_next_op: got %h lat %0d want %h lat %0d", out_data, lat, e, elat);
        end
        take();
    endtask

    task automatic test_async_reset();
        send(2'b00, 32'h0000_FFFF, 20);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b out_data=%h busy=%b want 0 1 0 0",
                     out_valid, in_ready, out_data, busy);
        end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat, elat, s;
        logic ba;
        logic [1:0] op;
        logic [WIDTH-1:0] d, e, r;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            s  = $urandom_range(0, WIDTH - 1);
            send(op, d, s);
            wait_valid(lat, ba);
            e = exp_q.pop_front();
            elat = lat_q.pop_front();
            checks++;
            if (out_data !== e || lat !== elat) begin
                errors++;
                $display("FAIL random%0d op=%0d s=%0d d=%h: got %h lat %0d want %h lat %0d",
                         i, op, s, d, out_data, lat, e, elat);
            end
            take();
        end
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            s = $urandom_range(1, WIDTH - 1);
            send(2'b11, d, s);
            wait_valid(lat, ba);
            r = out_data;
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            take();
            send(2'b11, r, WIDTH - s);
            wait_valid(lat, ba);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            checks++;
            if (out_data !== d) begin
                errors++;
                $display("FAIL ror_roundtrip%0d s=%0d: got %h want %h", i, s, out_data, d);
            end
            take();
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        test_reset();
        test_sll31();
        test_directed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
